grf_mp: RTL and testbench
=========================

Name: grf_mp

Overview:
- Parametrised multi-port general register file, the successor to the single-write/two-read GRF in the pipelined MIPS core.
- Provides NRD combinational read ports and two write ports (W0 = older stage, W1 = younger stage, W1 has priority), with same-cycle write-through bypass.
- Adds a per-register pending scoreboard. Decode claims a destination, writeback clears it, and each read port reports a busy flag for stall logic.
- Sits between decode (reads, claims) and the M/W stages (writes).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 is hardwired to zero: reads return 0, writes and claims to it are ignored.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*DW  packed read data, combinational.
- rd_busy  out  NRD  per read port: the addressed register is pending.
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1 (priority port).
- wa1  in  AW  write address, port 1.
- wd1  in  DW  write data, port 1.
- claim_en  in  1  mark a destination register pending.
- claim_addr  in  AW  register to mark pending.
- pend_vec  out  2**AW  current scoreboard bits, registered.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All registers and all pending bits become 0. Writes and claims in that cycle are ignored.
  - After the edge, rd_data is 0 for every address, rd_busy is 0 and pend_vec is 0.
  - A reset arriving mid-operation discards any pending claims.
- Write (reset==1):
  - At the rising edge, reg[wa0] <= wd0 if we0, and reg[wa1] <= wd1 if we1.
  - If both are enabled with wa0==wa1, only wd1 is stored.
  - With ZERO_REG=1, address 0 is never written.
- Read, per port k, combinational, evaluated in this priority order:
  - (a) ZERO_REG && addr==0 -> 0.
  - (b) reset==1 && we1 && wa1==addr -> wd1.
  - (c) reset==1 && we0 && wa0==addr -> wd0.
  - (d) otherwise reg[addr].
  - Bypass is disabled while reset==0.
- Scoreboard, at the rising edge with reset==1:
  - A write on either port clears pend[wa].
  - claim_en sets pend[claim_addr].
  - Claim and write to the same address in the same cycle: the claim wins and the bit ends at 1, because the claim is a newer producer.
  - Claims to address 0 are ignored when ZERO_REG=1.
  - Claiming an already-pending register leaves it at 1. There is no counting.
- rd_busy[k]:
  - Asserted when pend[addr_k] is 1 and no enabled write to addr_k occurs in the current cycle, since that write's data is already bypassed.
  - Forced to 0 for address 0 when ZERO_REG=1.
- pend_vec reflects the registered scoreboard only, with no bypass.
- Latency:
  - Write to read: 0 cycles via bypass, then stable from the next cycle.
  - Claim to busy: 1 cycle.
- Out-of-range parameters (NRD outside 1..4) are not supported. No $display logging in this block; trace output belongs to the top level.

Test Plan:
- Reset: hold reset=0 for 2 edges after writing 0xDEADBEEF to r5, then release -> rd_data(r5)=0, pend_vec=0, rd_busy=0.
- Bypass/priority: we0=1, wa0=8, wd0=0x11; we1=1, wa1=8, wd1=0x22; read r8 on both ports -> 0x22 same cycle, and r8 holds 0x22 after the edge.
- Zero register: we1=1, wa1=0, wd1=0xFFFFFFFF; claim_en=1, claim_addr=0 -> rd_data(r0)=0 before and after the edge, pend_vec[0]=0, rd_busy=0.
- Scoreboard: claim r3 at cycle n -> rd_busy=1 for r3 from cycle n+1. Write r3=0x1234 via we0 at cycle n+3 -> rd_busy=0 and rd_data=0x1234 in cycle n+3, and pend_vec[3]=0 after the edge.
- Simultaneous claim and write: claim r7 and we1 write r7=0x55 in the same cycle -> after the edge pend_vec[7]=1, r7=0x55, and rd_busy for r7 =1 in the next cycle.
- Parameter sweep: DW=16, AW=3, NRD=4, ZERO_REG=0 -> r0 is writable; 4 ports read r0..r3 independently with correct values after random writes, checked against a reference model over 1000 cycles.

Source files
------------

// File: rtl/grf_mp.sv
// Multi-port general register file: NRD combinational read ports, two write
// ports (W1 wins), same-cycle write-through bypass and a per-register pending scoreboard.
module grf_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*DW-1:0]   rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [DW-1:0]       wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [DW-1:0]       wd1,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [2**AW-1:0]    pend_vec
);

  localparam int   DEPTH = 2**AW;
  localparam logic ZR    = (ZERO_REG != 0);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic             wr0_ok;
  logic             wr1_ok;
  logic             claim_ok;

  assign wr0_ok   = we0 && !(ZR && (wa0 == '0));
  assign wr1_ok   = we1 && !(ZR && (wa1 == '0));
  assign claim_ok = claim_en && !(ZR && (claim_addr == '0));

  // Writes retire their producer; a claim in the same cycle is newer and wins.
  always_comb begin
    pend_nxt = pend;
    if (we0) pend_nxt[wa0] = 1'b0;
    if (we1) pend_nxt[wa1] = 1'b0;
    if (claim_ok) pend_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (wr0_ok) regs[wa0] <= wd0;
      if (wr1_ok) regs[wa1] <= wd1;
      pend <= pend_nxt;
    end
  end

  assign pend_vec = pend;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          hit0;
    logic          hit1;

    assign addr    = rd_addr[k*AW +: AW];
    assign is_zero = ZR && (addr == '0);
    assign hit1    = reset && we1 && (wa1 == addr);
    assign hit0    = reset && we0 && (wa0 == addr);

    assign rd_data[k*DW +: DW] = is_zero ? '0  :
                                 hit1    ? wd1 :
                                 hit0    ? wd0 : regs[addr];
    // A write landing this cycle is already bypassed, so it does not stall.
    assign rd_busy[k] = pend[addr] && !hit0 && !hit1 && !is_zero;
  end

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: directed scenarios on the default configuration, then
// randomized traffic on it and on a DW=16/AW=3/NRD=4/ZERO_REG=0 instance against a reference model.
module tb_grf_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic [9:0]  rda;
  logic [63:0] rdd_a;
  logic [1:0]  busy_a;
  logic        we0a, we1a, cla;
  logic [4:0]  wa0a, wa1a, caa;
  logic [31:0] wd0a, wd1a;
  logic [31:0] pv_a;

  // Instance B: parameter sweep
  logic [11:0] rdb;
  logic [63:0] rdd_b;
  logic [3:0]  busy_b;
  logic        we0b, we1b, clb;
  logic [2:0]  wa0b, wa1b, cab;
  logic [15:0] wd0b, wd1b;
  logic [7:0]  pv_b;

  grf_mp dut_a (
    .clk(clk), .reset(reset), .rd_addr(rda), .rd_data(rdd_a), .rd_busy(busy_a),
    .we0(we0a), .wa0(wa0a), .wd0(wd0a), .we1(we1a), .wa1(wa1a), .wd1(wd1a),
    .claim_en(cla), .claim_addr(caa), .pend_vec(pv_a)
  );

  grf_mp #(.DW(16), .AW(3), .NRD(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rdb), .rd_data(rdd_b), .rd_busy(busy_b),
    .we0(we0b), .wa0(wa0b), .wd0(wd0b), .we1(we1b), .wa1(wa1b), .wd1(wd1b),
    .claim_en(clb), .claim_addr(cab), .pend_vec(pv_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: model 0 is instance A, model 1 is instance B
  logic [31:0] mreg  [2][32];
  logic        mpend [2][32];

  function automatic logic [31:0] m_read(int m, bit zr, logic [4:0] a, logic rst,
      logic w0, logic [4:0] a0, logic [31:0] d0, logic w1, logic [4:0] a1, logic [31:0] d1);
    if (zr && a == 0) return 32'h0;
    if (rst && w1 && a1 == a) return d1;
    if (rst && w0 && a0 == a) return d0;
    return mreg[m][a];
  endfunction

  function automatic logic m_busy(int m, bit zr, logic [4:0] a,
      logic w0, logic [4:0] a0, logic w1, logic [4:0] a1);
    if (zr && a == 0) return 1'b0;
    if ((w0 && a0 == a) || (w1 && a1 == a)) return 1'b0;
    return mpend[m][a];
  endfunction

  function automatic void m_update(int m, bit zr, logic rst,
      logic w0, logic [4:0] a0, logic [31:0] d0, logic w1, logic [4:0] a1, logic [31:0] d1,
      logic c, logic [4:0] ca);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        mreg[m][i]  = 32'h0;
        mpend[m][i] = 1'b0;
      end
      return;
    end
    if (w0 && !(zr && a0 == 0)) mreg[m][a0] = d0;
    if (w1 && !(zr && a1 == 0)) mreg[m][a1] = d1;
    if (w0) mpend[m][a0] = 1'b0;
    if (w1) mpend[m][a1] = 1'b0;
    if (c && !(zr && ca == 0)) mpend[m][ca] = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_update(0, 1'b1, reset, we0a, wa0a, wd0a, we1a, wa1a, wd1a, cla, caa);
    m_update(1, 1'b0, reset, we0b, {2'b0, wa0b}, {16'h0, wd0b}, we1b, {2'b0, wa1b},
             {16'h0, wd1b}, clb, {2'b0, cab});
    #1;
  endtask

  task automatic idle();
    we0a = 0; we1a = 0; cla = 0; wa0a = 0; wa1a = 0; caa = 0; wd0a = 0; wd1a = 0;
    we0b = 0; we1b = 0; clb = 0; wa0b = 0; wa1b = 0; cab = 0; wd0b = 0; wd1b = 0;
  endtask

  task automatic check_model();
    logic [31:0] pexp_a;
    logic [7:0]  pexp_b;
    for (int k = 0; k < 2; k++) begin
      check("a_rd_data", rdd_a[k*32 +: 32],
            m_read(0, 1'b1, rda[k*5 +: 5], reset, we0a, wa0a, wd0a, we1a, wa1a, wd1a));
      if (reset)
        check("a_rd_busy", {31'h0, busy_a[k]},
              {31'h0, m_busy(0, 1'b1, rda[k*5 +: 5], we0a, wa0a, we1a, wa1a)});
    end
    for (int k = 0; k < 4; k++) begin
      check("b_rd_data", {16'h0, rdd_b[k*16 +: 16]},
            m_read(1, 1'b0, {2'b0, rdb[k*3 +: 3]}, reset, we0b, {2'b0, wa0b}, {16'h0, wd0b},
                   we1b, {2'b0, wa1b}, {16'h0, wd1b}));
      if (reset)
        check("b_rd_busy", {31'h0, busy_b[k]},
              {31'h0, m_busy(1, 1'b0, {2'b0, rdb[k*3 +: 3]}, we0b, {2'b0, wa0b},
                             we1b, {2'b0, wa1b})});
    end
    for (int i = 0; i < 32; i++) pexp_a[i] = mpend[0][i];
    for (int i = 0; i < 8; i++)  pexp_b[i] = mpend[1][i];
    check("a_pend_vec", pv_a, pexp_a);
    check("b_pend_vec", {24'h0, pv_b}, {24'h0, pexp_b});
  endtask

  function automatic logic [4:0] rnd_a_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    rda = 0; rdb = 0;
    reset = 1'b0;
    tick(); tick();
    check("rst_pend_a", pv_a, 32'h0);
    check("rst_pend_b", {24'h0, pv_b}, 32'h0);
    reset = 1'b1;

    // Reset mid-operation clears data and discards claims
    we0a = 1; wa0a = 5; wd0a = 32'hDEADBEEF; cla = 1; caa = 9;
    tick(); idle();
    rda = {5'd9, 5'd5}; #1;
    check("pre_rst_r5", rdd_a[31:0], 32'hDEADBEEF);
    check("pre_rst_busy9", {31'h0, busy_a[1]}, 32'h1);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1; #1;
    check("rst_r5", rdd_a[31:0], 32'h0);
    check("rst_pend", pv_a, 32'h0);
    check("rst_busy", {30'h0, busy_a}, 32'h0);

    // Dual write to same address: W1 wins, bypassed same cycle
    we0a = 1; wa0a = 8; wd0a = 32'h11; we1a = 1; wa1a = 8; wd1a = 32'h22;
    rda = {5'd8, 5'd8}; #1;
    check("byp_p0", rdd_a[31:0], 32'h22);
    check("byp_p1", rdd_a[63:32], 32'h22);
    tick(); idle(); #1;
    check("held_r8", rdd_a[31:0], 32'h22);

    // Zero register ignores writes and claims
    we1a = 1; wa1a = 0; wd1a = 32'hFFFFFFFF; cla = 1; caa = 0; rda = 0; #1;
    check("r0_before", rdd_a[31:0], 32'h0);
    tick(); idle(); #1;
    check("r0_after", rdd_a[31:0], 32'h0);
    check("r0_pend", {31'h0, pv_a[0]}, 32'h0);
    check("r0_busy", {31'h0, busy_a[0]}, 32'h0);

    // Claim r3 at cycle n, write it at n+3
    cla = 1; caa = 3; rda = {5'd0, 5'd3};
    tick(); idle(); #1;
    check("sb_busy_n1", {31'h0, busy_a[0]}, 32'h1);
    tick(); #1;
    check("sb_busy_n2", {31'h0, busy_a[0]}, 32'h1);
    tick();
    we0a = 1; wa0a = 3; wd0a = 32'h1234; #1;
    check("sb_busy_n3", {31'h0, busy_a[0]}, 32'h0);
    check("sb_data_n3", rdd_a[31:0], 32'h1234);
    tick(); idle(); #1;
    check("sb_pend3", {31'h0, pv_a[3]}, 32'h0);

    // Claim and write same register same cycle: claim wins
    cla = 1; caa = 7; we1a = 1; wa1a = 7; wd1a = 32'h55; rda = {5'd7, 5'd7};
    tick(); idle(); #1;
    check("cw_pend7", {31'h0, pv_a[7]}, 32'h1);
    check("cw_r7", rdd_a[31:0], 32'h55);
    check("cw_busy7", {31'h0, busy_a[1]}, 32'h1);

    // Randomized traffic on both instances against the model
    for (int c = 0; c < 1000; c++) begin
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      we0a = 1'($urandom); wa0a = rnd_a_addr(); wd0a = $urandom;
      we1a = 1'($urandom); wa1a = rnd_a_addr(); wd1a = $urandom;
      cla  = 1'($urandom); caa  = rnd_a_addr();
      rda  = {rnd_a_addr(), rnd_a_addr()};
      we0b = 1'($urandom); wa0b = 3'($urandom); wd0b = 16'($urandom);
      we1b = 1'($urandom); wa1b = 3'($urandom); wd1b = 16'($urandom);
      clb  = ($urandom_range(0, 3) == 0); cab = 3'($urandom);
      rdb  = (c % 4 == 0) ? {3'd3, 3'd2, 3'd1, 3'd0} : 12'($urandom);
      #1;
      check_model();
      tick();
    end
    reset = 1'b1;
    idle(); #1;
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
